shared_divider_rr: RTL

- N-channel shared sequential unsigned divider with round-robin arbitration.
- Generalises the current two-client divider and its single select line (speed, average speed) to NUM_CH clients.
- Adds per-channel request/acknowledge/done handshakes, remainder output and divide-by-zero flagging.
- Sits between the computation blocks (speed, average speed, future cadence/calorie) and replaces external select steering.

---
 rtl/shared_divider_rr.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shared_divider_rr.sv
// Shared sequential unsigned divider serving NUM_CH clients in round-robin order.
// One restoring step per cycle. The result registers and the done pulse are
// loaded together, so the outputs change only when done is asserted.
module shared_divider_rr #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*WIDTH-1:0] dividend_bus,
  input  logic [NUM_CH*WIDTH-1:0] divisor_bus,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       done,
  output logic [WIDTH-1:0]        quotient,
  output logic [WIDTH-1:0]        remainder,
  output logic                    div_by_zero,
  output logic                    busy,
  output logic [CH_W-1:0]         owner
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   owner_q;
  logic [NUM_CH-1:0] ack_q;
  logic [NUM_CH-1:0] done_q;
  logic [WIDTH-1:0]  dvd_q;      // dividend shifts out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0]  dvs_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quot_out_q;
  logic [WIDTH-1:0]  rem_out_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbz_q;
  logic              busy_q;

  logic              grant_d;
  logic [CH_W-1:0]   sel_d;
  logic [CH_W-1:0]   ptr_d;
  int unsigned       scan_idx;

  logic [WIDTH:0]    trial_d;
  logic              fit_d;
  logic [WIDTH-1:0]  rem_d;

  // Round-robin pick: first requesting channel at or above the pointer, wrapping.
  always_comb begin
    grant_d  = 1'b0;
    sel_d    = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_idx = (32'(ptr_q) + i) % NUM_CH;
      if (!grant_d && req[CH_W'(scan_idx)]) begin
        grant_d = 1'b1;
        sel_d   = CH_W'(scan_idx);
      end
    end
    ptr_d = CH_W'((32'(sel_d) + 1) % NUM_CH);
  end

  // One restoring-division step on the current partial remainder.
  always_comb begin
    trial_d = {rem_q, dvd_q[WIDTH-1]};
    fit_d   = (trial_d >= {1'b0, dvs_q});
    rem_d   = fit_d ? WIDTH'(trial_d - {1'b0, dvs_q}) : trial_d[WIDTH-1:0];
  end

  // Controller, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      cnt_q      <= '0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          ack_q  <= '0;
          busy_q <= 1'b0;
          if (grant_d) begin
            dvd_q   <= dividend_bus[sel_d*WIDTH +: WIDTH];
            dvs_q   <= divisor_bus[sel_d*WIDTH +: WIDTH];
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            owner_q <= sel_d;
            ptr_q   <= ptr_d;
            ack_q   <= NUM_CH'(1) << sel_d;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          ack_q <= '0;
          rem_q <= rem_d;
          dvd_q <= {dvd_q[WIDTH-2:0], fit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // busy stays high into the cycle where done is visible.
          done_q     <= NUM_CH'(1) << owner_q;
          quot_out_q <= dvd_q;
          rem_out_q  <= rem_q;
          dbz_q      <= (dvs_q == '0);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule
